uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter BITWIDTH, default 8, data bits per frame; it SHALL equal the codebase `BITWIDTH define.
REQ-002 Parameter CLKDIV, default 16, Clk cycles per serial bit; even, >= 4.
REQ-003 Port Clk  input  1  system clock, all logic on posedge.
REQ-004 Port Rst  input  1  asynchronous, active-high reset.
REQ-005 Port RxD  input  1  asynchronous serial line; idles high; 8N1, LSB first.
REQ-006 Port dataOut  output  BITWIDTH  last correctly received byte; feeds the receive buffer data input.
REQ-007 Port WR  output  1  one-cycle write strobe to the receive buffer.
REQ-008 Port wpaddr  output  2  buffer slot address for the current WR.
REQ-009 Port FrameErr  output  1  one-cycle pulse on a bad stop bit.
REQ-010 Port Busy  output  1  high in every state except IDLE.

Function
REQ-011 RxD SHALL pass through a 2-flop synchronizer (rxs) before any use; rxs drives all decisions.
REQ-012 The FSM SHALL have states IDLE, START, DATA, STOP and WAITHI.
REQ-013 IDLE -> START when armed and rxs==0; T0 = that Clk edge; the bit counter clears.
REQ-014 START: sample at T0+CLKDIV/2; rxs==0 -> DATA; rxs==1 -> IDLE (glitch rejected, no output activity).
REQ-015 DATA: bit i (i=0..BITWIDTH-1) sampled at T0+CLKDIV/2+(i+1)*CLKDIV and shifted in LSB first; after the last bit -> STOP.
REQ-016 STOP: sample at T0+CLKDIV/2+(BITWIDTH+1)*CLKDIV.
REQ-017 Stop==1: on the next edge dataOut loads the shift register, WR=1 for exactly one cycle, state -> IDLE.
REQ-018 Stop==0: FrameErr=1 for one cycle, no WR, dataOut and wpaddr unchanged, state -> WAITHI.
REQ-019 WAITHI -> IDLE only after rxs==1; a held-low line (break) SHALL produce exactly one FrameErr.
REQ-020 During WR, wpaddr SHALL hold the slot being written; it increments mod 4 on the edge ending WR (3 -> 0).
REQ-021 No full check: wrap-around overwrites the oldest slot; overrun avoidance is the consumer's responsibility.
REQ-022 WR and FrameErr SHALL never be high in the same cycle.
REQ-023 A new start edge is accepted on the first IDLE cycle after WR (back-to-back frames, no gap).
REQ-024 The bit counter SHALL be $clog2(CLKDIV) bits wide; the bit index counts 0..BITWIDTH-1 and does not wrap.

Reset
REQ-025 Rst=1 SHALL immediately force: state IDLE, dataOut=0, WR=0, FrameErr=0, Busy=0, wpaddr=0, synchronizer flops=1, armed=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no WR and no FrameErr.
REQ-027 After reset release, armed SHALL set only once rxs==1 is seen, so a line already low is not taken as a start bit.

Structure
REQ-028 BITWIDTH SHALL come from the shared define header; FSM state encodings SHALL be localparams in the same shared header/package.
REQ-029 The synchronizer SHALL be the sub-module uart_rx_sync (2 flops, reset value 1); all other logic SHALL be in uart_rx.

Verification (CLKDIV=16, BITWIDTH=8)
REQ-030 Frame 0xA5 after reset -> WR high only in cycle T0+153, dataOut=0xA5, wpaddr=0 during WR and 1 after.
REQ-031 Five frames 0x01..0x04, 0x55 -> WR addresses 0,1,2,3,0; final dataOut=0x55; frames sent back-to-back are all received.
REQ-032 RxD low for 4 cycles, then high -> START aborts to IDLE; no WR, no FrameErr; Busy high for at most 10 cycles.
REQ-033 Frame 0x3C with stop bit 0, line held low 300 cycles, then frame 0x3C -> one FrameErr pulse, no WR for the bad frame; then WR with dataOut=0x3C at wpaddr 0.
REQ-034 Rst pulsed during data bit 3 with RxD then held low 40 cycles -> all outputs 0 at once, no WR or start while low; next frame 0x81 -> WR, dataOut=0x81, wpaddr=0.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the UART receiver.
//   RX_BITWIDTH : data bits per frame, taken from the `BITWIDTH define
//   ST_*_ENC    : FSM state encodings
//   state_t     : receiver FSM state type built from those encodings
// ---------------------------------------------------------------------------
`ifndef BITWIDTH
`define BITWIDTH 8
`endif

package uart_rx_pkg;

  localparam int RX_BITWIDTH = `BITWIDTH;

  localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
  localparam logic [2:0] ST_START_ENC  = 3'd1;
  localparam logic [2:0] ST_DATA_ENC   = 3'd2;
  localparam logic [2:0] ST_STOP_ENC   = 3'd3;
  localparam logic [2:0] ST_WAITHI_ENC = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_START  = ST_START_ENC,
    ST_DATA   = ST_DATA_ENC,
    ST_STOP   = ST_STOP_ENC,
    ST_WAITHI = ST_WAITHI_ENC
  } state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// ---------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer for the asynchronous serial line. Both flops reset
// to 1 (line idle level).
//   i_clk : system clock
//   i_rst : asynchronous active-high reset
//   i_d   : asynchronous input
//   o_q   : synchronized output
// ---------------------------------------------------------------------------
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], i_d};
    end
  end

  assign o_q = r_sync[1];

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// 8N1-style UART receiver (LSB first) writing received words into a 4-slot
// receive buffer addressed by a free-running wrap-around pointer.
//   Clk      : system clock, all logic on posedge
//   Rst      : asynchronous active-high reset
//   RxD      : asynchronous serial input, idles high
//   dataOut  : last correctly received word (receive buffer data input)
//   WR       : one-cycle write strobe to the receive buffer
//   wpaddr   : buffer slot written by the current WR; advances mod 4 after
//   FrameErr : one-cycle pulse on a bad stop bit
//   Busy     : high whenever the FSM is not idle
// Parameters: BITWIDTH (>= 2) data bits, CLKDIV (even, >= 4) clocks per bit.
// ---------------------------------------------------------------------------
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int BITWIDTH = RX_BITWIDTH,
  parameter int CLKDIV   = 16
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                RxD,
  output logic [BITWIDTH-1:0] dataOut,
  output logic                WR,
  output logic [1:0]          wpaddr,
  output logic                FrameErr,
  output logic                Busy
);

  localparam int CW = $clog2(CLKDIV);
  localparam int IW = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKDIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKDIV - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(BITWIDTH - 1);

  logic                w_rxs;
  state_t              r_state;
  state_t              w_state_next;
  logic [CW-1:0]       r_cnt;
  logic [IW-1:0]       r_idx;
  logic [BITWIDTH-1:0] r_shift;
  logic [BITWIDTH-1:0] r_data;
  logic                r_stop_seen;
  logic                r_stop_bit;
  logic                r_wr;
  logic                r_ferr;
  logic [1:0]          r_wpaddr;
  logic                r_armed;
  logic [1:0]          r_warm;

  logic w_cnt_clr;
  logic w_idx_clr;
  logic w_shift;
  logic w_stop_cap;
  logic w_wr_set;
  logic w_ferr_set;

  uart_rx_sync u_sync (
    .i_clk (Clk),
    .i_rst (Rst),
    .i_d   (RxD),
    .o_q   (w_rxs)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_clr    = 1'b0;
    w_idx_clr    = 1'b0;
    w_shift      = 1'b0;
    w_stop_cap   = 1'b0;
    w_wr_set     = 1'b0;
    w_ferr_set   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_armed && !w_rxs) begin
          w_state_next = ST_START;
          w_cnt_clr    = 1'b1;
          w_idx_clr    = 1'b1;
        end
      end
      ST_START: begin
        // Mid start bit: a line back high means the falling edge was a glitch.
        if (r_cnt == HALF_M1) begin
          w_cnt_clr = 1'b1;
          if (w_rxs) begin
            w_state_next = ST_IDLE;
          end else begin
            w_state_next = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_clr = 1'b1;
          w_shift   = 1'b1;
          if (r_idx == LAST_IDX) begin
            w_state_next = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        // The stop bit is captured mid-bit; the write or error is issued on
        // the following edge.
        if (r_stop_seen) begin
          if (r_stop_bit) begin
            w_wr_set     = 1'b1;
            w_state_next = ST_IDLE;
          end else begin
            w_ferr_set   = 1'b1;
            w_state_next = ST_WAITHI;
          end
        end else if (r_cnt == FULL_M1) begin
          w_stop_cap = 1'b1;
        end
      end
      ST_WAITHI: begin
        // Wait out a break so a held-low line reports only one error.
        if (w_rxs) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_stop_seen <= 1'b0;
      r_stop_bit  <= 1'b0;
      r_wr        <= 1'b0;
      r_ferr      <= 1'b0;
      r_wpaddr    <= 2'd0;
      r_armed     <= 1'b0;
      r_warm      <= 2'd0;
    end else begin
      r_cnt <= w_cnt_clr ? '0 : r_cnt + CW'(1);

      if (w_idx_clr) begin
        r_idx <= '0;
      end else if (w_shift && (r_idx != LAST_IDX)) begin
        r_idx <= r_idx + IW'(1);
      end

      if (w_shift) begin
        r_shift <= {w_rxs, r_shift[BITWIDTH-1:1]};
      end

      if (w_stop_cap) begin
        r_stop_seen <= 1'b1;
        r_stop_bit  <= w_rxs;
      end else if (w_wr_set || w_ferr_set) begin
        r_stop_seen <= 1'b0;
      end

      r_wr   <= w_wr_set;
      r_ferr <= w_ferr_set;

      if (w_wr_set) begin
        r_data <= r_shift;
      end

      // Pointer holds during the strobe and advances on the edge that ends it.
      if (r_wr) begin
        r_wpaddr <= r_wpaddr + 2'd1;
      end

      // The synchronizer's reset value is not a line observation: only arm
      // once both flops have been reloaded from RxD and the line reads high.
      if (r_warm != 2'd2) begin
        r_warm <= r_warm + 2'd1;
      end
      if ((r_warm == 2'd2) && w_rxs) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign dataOut  = r_data;
  assign WR       = r_wr;
  assign FrameErr = r_ferr;
  assign wpaddr   = r_wpaddr;
  assign Busy     = (r_state != ST_IDLE);

endmodule
